// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set 2 scan-code decoder: resolves E0/F0/E1 prefixes into key events
// and tracks Shift and Caps Lock for US-layout ASCII translation.
module ps2_scancode_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_code_valid,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_released,
    output logic       key_extended,
    output logic [7:0] ascii,
    output logic       shift_active,
    output logic       caps_lock,
    output logic       sequence_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] BRK     = 3'd1;
    localparam logic [2:0] EXT     = 3'd2;
    localparam logic [2:0] EXT_BRK = 3'd3;
    localparam logic [2:0] PAUSE   = 3'd4;

    logic [2:0]    state, state_n;
    logic [2:0]    pcnt, pcnt_n;
    logic [TW-1:0] tcnt;
    logic          lshift, rshift, caps_held;

    logic       emit, emit_rel, emit_ext, err;
    logic [7:0] emit_code;
    logic [7:0] ascii_n;
    logic       is_f0, is_e0, is_e1, ignored, timeout;

    function automatic logic [7:0] to_ascii(
        input logic [7:0] c,
        input logic       sh,
        input logic       cl
    );
        logic [7:0] a;
        a = 8'h00;
        case (c)
            8'h1C: a = 8'h61;
            8'h32: a = 8'h62;
            8'h21: a = 8'h63;
            8'h23: a = 8'h64;
            8'h24: a = 8'h65;
            8'h2B: a = 8'h66;
            8'h34: a = 8'h67;
            8'h33: a = 8'h68;
            8'h43: a = 8'h69;
            8'h3B: a = 8'h6A;
            8'h42: a = 8'h6B;
            8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;
            8'h31: a = 8'h6E;
            8'h44: a = 8'h6F;
            8'h4D: a = 8'h70;
            8'h15: a = 8'h71;
            8'h2D: a = 8'h72;
            8'h1B: a = 8'h73;
            8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;
            8'h2A: a = 8'h76;
            8'h1D: a = 8'h77;
            8'h22: a = 8'h78;
            8'h35: a = 8'h79;
            8'h1A: a = 8'h7A;
            default: a = 8'h00;
        endcase
        // Letters go upper-case when exactly one of Shift/Caps is active
        if (a != 8'h00) begin
            if (sh ^ cl) a = a - 8'h20;
        end else begin
            case (c)
                8'h45: a = sh ? 8'h29 : 8'h30;
                8'h16: a = sh ? 8'h21 : 8'h31;
                8'h1E: a = sh ? 8'h40 : 8'h32;
                8'h26: a = sh ? 8'h23 : 8'h33;
                8'h25: a = sh ? 8'h24 : 8'h34;
                8'h2E: a = sh ? 8'h25 : 8'h35;
                8'h36: a = sh ? 8'h5E : 8'h36;
                8'h3D: a = sh ? 8'h26 : 8'h37;
                8'h3E: a = sh ? 8'h2A : 8'h38;
                8'h46: a = sh ? 8'h28 : 8'h39;
                8'h29: a = 8'h20;
                8'h5A: a = 8'h0D;
                8'h66: a = 8'h08;
                default: a = 8'h00;
            endcase
        end
        return a;
    endfunction

    assign is_f0   = (scan_code == 8'hF0);
    assign is_e0   = (scan_code == 8'hE0);
    assign is_e1   = (scan_code == 8'hE1);
    assign ignored = (scan_code == 8'h00) || (scan_code == 8'hAA) ||
                     (scan_code == 8'hEE) || (scan_code == 8'hFA) ||
                     (scan_code == 8'hFC) || (scan_code == 8'hFE) ||
                     (scan_code == 8'hFF);
    assign timeout = (state != IDLE) &&
                     (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_n   = state;
        pcnt_n    = pcnt;
        emit      = 1'b0;
        emit_rel  = 1'b0;
        emit_ext  = 1'b0;
        emit_code = scan_code;
        err       = 1'b0;
        if (scan_code_valid) begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (is_f0) begin
                        state_n = BRK;
                    end else if (is_e0) begin
                        state_n = EXT;
                    end else if (is_e1) begin
                        state_n = PAUSE;
                        pcnt_n  = 3'd0;
                    end else if (!ignored) begin
                        emit = 1'b1;
                    end
                end
                (state == PAUSE): begin
                    if (pcnt == 3'd6) begin
                        emit      = 1'b1;
                        emit_ext  = 1'b1;
                        emit_code = 8'h77;
                        state_n   = IDLE;
                    end else begin
                        pcnt_n = pcnt + 3'd1;
                    end
                end
                (state == BRK),
                (state == EXT),
                (state == EXT_BRK): begin
                    // A stray prefix restarts decoding; F0 is only legal in EXT
                    if (is_e0 || is_e1 || (is_f0 && state != EXT)) begin
                        err = 1'b1;
                        if (is_e0) begin
                            state_n = EXT;
                        end else if (is_e1) begin
                            state_n = PAUSE;
                            pcnt_n  = 3'd0;
                        end else begin
                            state_n = BRK;
                        end
                    end else if (is_f0) begin
                        state_n = EXT_BRK;
                    end else begin
                        emit     = 1'b1;
                        emit_rel = (state != EXT);
                        emit_ext = (state != BRK);
                        state_n  = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (timeout) begin
            err     = 1'b1;
            state_n = IDLE;
        end
    end

    assign ascii_n = emit_ext ? 8'h00 :
                     to_ascii(emit_code, shift_active, caps_lock);
    assign shift_active = lshift | rshift;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            pcnt           <= 3'd0;
            tcnt           <= '0;
            lshift         <= 1'b0;
            rshift         <= 1'b0;
            caps_held      <= 1'b0;
            caps_lock      <= 1'b0;
            key_valid      <= 1'b0;
            key_code       <= 8'h00;
            key_released   <= 1'b0;
            key_extended   <= 1'b0;
            ascii          <= 8'h00;
            sequence_error <= 1'b0;
        end else begin
            state          <= state_n;
            pcnt           <= pcnt_n;
            tcnt           <= (scan_code_valid || state == IDLE) ?
                              '0 : tcnt + TW'(1);
            key_valid      <= emit;
            sequence_error <= err;
            if (emit) begin
                key_code     <= emit_code;
                key_released <= emit_rel;
                key_extended <= emit_ext;
                ascii        <= ascii_n;
            end
            if (emit && !emit_ext) begin
                case (emit_code)
                    8'h12: lshift <= !emit_rel;
                    8'h59: rshift <= !emit_rel;
                    8'h58: begin
                        if (emit_rel) begin
                            caps_held <= 1'b0;
                        end else begin
                            if (!caps_held) caps_lock <= ~caps_lock;
                            caps_held <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
